// File: rtl/alu_unit.sv
`default_nettype none
// ============================================================================
//  Module   : alu_unit
//  Purpose  : Integer ALU for an out-of-order core. Computes the result of an
//             issued instruction in the same cycle it is issued and parks it
//             in a small circular result queue until the common data bus
//             grants it. The queue head is presented combinationally as the
//             bypass/broadcast value.
//  Ports    : clk_in, rst_in (async, active-high), rdy_in (global enable),
//             flush_enable (sync flush), rs2alu_* (issue bundle),
//             cdb_grant (head accepted), alu_full (backpressure),
//             alu2rs_bypass_* (head tag/value), alu_jump/alu_target (head
//             control-flow outcome).
//  Revision : 1.0  initial release
// ============================================================================
module alu_unit #(
   parameter int FIFO_DEPTH  = 4,
   parameter int FULL_THRESH = 3
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        flush_enable,
   input  logic        rs2alu_enable,
   input  logic [31:0] rs2alu_rs1,
   input  logic [31:0] rs2alu_rs2,
   input  logic [31:0] rs2alu_imm,
   input  logic [5:0]  rs2alu_ins_type,
   input  logic [31:0] rs2alu_pc,
   input  logic [3:0]  rs2alu_reorder,
   input  logic        cdb_grant,
   output logic        alu_full,
   output logic        alu2rs_bypass_enable,
   output logic [3:0]  alu2rs_bypass_reorder,
   output logic [31:0] alu2rs_bypass_value,
   output logic        alu_jump,
   output logic [31:0] alu_target
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   // Instruction-type encoding shared with the reservation station.
   localparam logic [5:0] C_ADD  = 6'd1,  C_SUB   = 6'd2,  C_AND  = 6'd3;
   localparam logic [5:0] C_OR   = 6'd4,  C_XOR   = 6'd5,  C_SLT  = 6'd6;
   localparam logic [5:0] C_SLTU = 6'd7,  C_SLL   = 6'd8,  C_SRL  = 6'd9;
   localparam logic [5:0] C_SRA  = 6'd10, C_ADDI  = 6'd11, C_SLTI = 6'd12;
   localparam logic [5:0] C_SLTIU= 6'd13, C_XORI  = 6'd14, C_ORI  = 6'd15;
   localparam logic [5:0] C_ANDI = 6'd16, C_SLLI  = 6'd17, C_SRLI = 6'd18;
   localparam logic [5:0] C_SRAI = 6'd19, C_LUI   = 6'd20, C_AUIPC= 6'd21;
   localparam logic [5:0] C_JAL  = 6'd22, C_JALR  = 6'd23, C_BEQ  = 6'd24;
   localparam logic [5:0] C_BNE  = 6'd25, C_BLT   = 6'd26, C_BGE  = 6'd27;
   localparam logic [5:0] C_BLTU = 6'd28, C_BGEU  = 6'd29;

   // ---------------------------------------------------------------- compute
   logic [31:0] w_op2;
   logic [31:0] w_value;
   logic        w_jump;
   logic [31:0] w_target;
   logic [31:0] w_pc4;
   logic [31:0] w_pcimm;
   logic        w_taken;

   assign w_pc4   = rs2alu_pc + 32'd4;
   assign w_pcimm = rs2alu_pc + rs2alu_imm;

   // Immediate forms reuse the register datapath with imm in place of rs2.
   always_comb begin
      w_op2 = rs2alu_rs2;
      case (rs2alu_ins_type)
         C_ADDI, C_SLTI, C_SLTIU, C_XORI, C_ORI, C_ANDI,
         C_SLLI, C_SRLI, C_SRAI: w_op2 = rs2alu_imm;
         default:                w_op2 = rs2alu_rs2;
      endcase
   end

   always_comb begin
      w_value  = 32'd0;
      w_jump   = 1'b0;
      w_target = w_pc4;
      w_taken  = 1'b0;
      case (rs2alu_ins_type)
         C_ADD,  C_ADDI:  w_value = rs2alu_rs1 + w_op2;
         C_SUB:           w_value = rs2alu_rs1 - w_op2;
         C_AND,  C_ANDI:  w_value = rs2alu_rs1 & w_op2;
         C_OR,   C_ORI:   w_value = rs2alu_rs1 | w_op2;
         C_XOR,  C_XORI:  w_value = rs2alu_rs1 ^ w_op2;
         C_SLT,  C_SLTI:  w_value = {31'd0, $signed(rs2alu_rs1) < $signed(w_op2)};
         C_SLTU, C_SLTIU: w_value = {31'd0, rs2alu_rs1 < w_op2};
         C_SLL,  C_SLLI:  w_value = rs2alu_rs1 << w_op2[4:0];
         C_SRL,  C_SRLI:  w_value = rs2alu_rs1 >> w_op2[4:0];
         C_SRA,  C_SRAI:  w_value = $unsigned($signed(rs2alu_rs1) >>> w_op2[4:0]);
         C_LUI:           w_value = rs2alu_imm;
         C_AUIPC:         w_value = w_pcimm;
         C_JAL: begin
            w_value  = w_pc4;
            w_jump   = 1'b1;
            w_target = w_pcimm;
         end
         C_JALR: begin
            w_value  = w_pc4;
            w_jump   = 1'b1;
            w_target = (rs2alu_rs1 + rs2alu_imm) & ~32'd1;
         end
         C_BEQ, C_BNE, C_BLT, C_BGE, C_BLTU, C_BGEU: begin
            case (rs2alu_ins_type)
               C_BEQ:   w_taken = (rs2alu_rs1 == rs2alu_rs2);
               C_BNE:   w_taken = (rs2alu_rs1 != rs2alu_rs2);
               C_BLT:   w_taken = ($signed(rs2alu_rs1) <  $signed(rs2alu_rs2));
               C_BGE:   w_taken = ($signed(rs2alu_rs1) >= $signed(rs2alu_rs2));
               C_BLTU:  w_taken = (rs2alu_rs1 <  rs2alu_rs2);
               default: w_taken = (rs2alu_rs1 >= rs2alu_rs2);
            endcase
            w_jump   = w_taken;
            w_target = w_taken ? w_pcimm : w_pc4;
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------------ result queue
   logic [3:0]    r_q_tag   [FIFO_DEPTH];
   logic [31:0]   r_q_value [FIFO_DEPTH];
   logic          r_q_jump  [FIFO_DEPTH];
   logic [31:0]   r_q_target[FIFO_DEPTH];
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_count;

   logic          w_pop;
   logic          w_push;
   logic [PW-1:0] w_head_nxt;
   logic [PW-1:0] w_tail_nxt;

   assign w_pop  = cdb_grant && (r_count != '0) && rdy_in && !flush_enable;
   // A push into a full queue is only legal when the head leaves this cycle.
   assign w_push = rs2alu_enable && rdy_in && !flush_enable &&
                   ((r_count != CW'(FIFO_DEPTH)) || w_pop);

   assign w_head_nxt = (r_head == PW'(FIFO_DEPTH - 1)) ? '0 : r_head + 1'b1;
   assign w_tail_nxt = (r_tail == PW'(FIFO_DEPTH - 1)) ? '0 : r_tail + 1'b1;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_q_tag[i]    <= '0;
            r_q_value[i]  <= '0;
            r_q_jump[i]   <= 1'b0;
            r_q_target[i] <= '0;
         end
      end else if (flush_enable) begin
         // Flush wins over rdy_in: stale speculative results must vanish.
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (rdy_in) begin
         if (w_push) begin
            r_q_tag[r_tail]    <= rs2alu_reorder;
            r_q_value[r_tail]  <= w_value;
            r_q_jump[r_tail]   <= w_jump;
            r_q_target[r_tail] <= w_target;
            r_tail             <= w_tail_nxt;
         end
         if (w_pop) begin
            r_head <= w_head_nxt;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Registered-count based, so the threshold leaves room for one issue
   // already in flight from the reservation station.
   assign alu_full              = (r_count >= CW'(FULL_THRESH));
   assign alu2rs_bypass_enable  = (r_count != '0);
   assign alu2rs_bypass_reorder = r_q_tag[r_head];
   assign alu2rs_bypass_value   = r_q_value[r_head];
   assign alu_jump              = r_q_jump[r_head];
   assign alu_target            = r_q_target[r_head];

endmodule
`default_nettype wire
